// File: rtl/bcd_converter_8b_pkg.sv
// Shared constants for the binary-to-BCD converter: FSM encoding and BCD digit geometry.
package bcd_converter_8b_pkg;
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SHIFT  = 2'd1;
  localparam logic [1:0] ST_FINISH = 2'd2;

  localparam int         DIGITS      = 3;
  localparam int         NIB_W       = 4;
  localparam logic [3:0] ADD3_THRESH = 4'd5;
endpackage

// File: rtl/bcd_converter_8b_add3_cell.sv
// Double-dabble correction cell: adds 3 to a BCD nibble of 5 or more; purely combinational.
module bcd_add3_cell
  import bcd_converter_8b_pkg::*;
(
  input  logic [NIB_W-1:0] din,
  output logic [NIB_W-1:0] dout
);
  assign dout = (din >= ADD3_THRESH) ? din + 4'd3 : din;
endmodule

// File: rtl/bcd_converter_8b.sv
// Iterative double-dabble binary->BCD converter; DONE pulses WIDTH+1 edges after START, which is ignored while BUSY.
// Define BCD_CONV_BLANK_EN to register leading-zero BLANK flags with the digits; otherwise BLANK is tied low.
module bcd_converter_8b
  import bcd_converter_8b_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             START,
  input  logic [WIDTH-1:0] DATA,
  input  logic             SIGNED_MODE,
  output logic [3:0]       BCD_HUN,
  output logic [3:0]       BCD_TEN,
  output logic [3:0]       BCD_UNI,
  output logic             SIGN,
  output logic             BUSY,
  output logic             DONE,
  output logic [1:0]       BLANK
);
  localparam int BCD_W = DIGITS * NIB_W;
  localparam int SR_W  = BCD_W + WIDTH;

  logic [1:0]       state;
  logic [3:0]       cnt;
  logic [SR_W-1:0]  sr;
  logic             sign_lat;
  logic             neg;
  logic [WIDTH-1:0] mag;
  logic [BCD_W-1:0] adj;
  logic [3:0]       acc_hun;
  logic [3:0]       acc_ten;
  logic [3:0]       acc_uni;

  // Two's-complement negate in WIDTH bits read as unsigned is exact, including the most negative value.
  assign neg = SIGNED_MODE & DATA[WIDTH-1];
  assign mag = neg ? (~DATA) + WIDTH'(1) : DATA;

  for (genvar d = 0; d < DIGITS; d++) begin : g_dig
    bcd_add3_cell u_add3 (
      .din  (sr[WIDTH + d*NIB_W +: NIB_W]),
      .dout (adj[d*NIB_W +: NIB_W])
    );
  end

  assign acc_uni = sr[WIDTH +: 4];
  assign acc_ten = sr[WIDTH + 4 +: 4];
  assign acc_hun = sr[WIDTH + 8 +: 4];
  assign BUSY    = (state != ST_IDLE);

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      sr       <= '0;
      sign_lat <= 1'b0;
      BCD_HUN  <= '0;
      BCD_TEN  <= '0;
      BCD_UNI  <= '0;
      SIGN     <= 1'b0;
      DONE     <= 1'b0;
    end else begin
      DONE <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (START) begin
            sr       <= {{BCD_W{1'b0}}, mag};
            sign_lat <= neg;
            cnt      <= '0;
            state    <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          // The bit leaving the top is always 0; rotating it into the operand LSB keeps every bit live
          // and it can never travel far enough to reach the BCD field.
          sr  <= {adj[BCD_W-2:0], sr[WIDTH-1:0], adj[BCD_W-1]};
          cnt <= cnt + 4'd1;
          if (cnt == 4'(WIDTH - 1)) state <= ST_FINISH;
        end
        ST_FINISH: begin
          BCD_HUN <= acc_hun;
          BCD_TEN <= acc_ten;
          BCD_UNI <= acc_uni;
          SIGN    <= sign_lat;
          DONE    <= 1'b1;
          state   <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef BCD_CONV_BLANK_EN
  always_ff @(posedge CLK) begin
    if (!RST_N) BLANK <= 2'b00;
    else if (state == ST_FINISH)
      BLANK <= {acc_hun == 4'd0, (acc_hun == 4'd0) && (acc_ten == 4'd0)};
  end
`else
  assign BLANK = 2'b00;
`endif
endmodule
